systolic_feeder: RTL and testbench

- Operand source for the N×N systolic multiplier array.
- Accepts matrix A row-by-row and matrix B column-by-column over a valid/ready load port, and buffers them.
- Replays them as per-row a-streams and per-column b-streams: skewed for registered-hop arrays, or broadcast for pass-through arrays.
- Signals completion once the last product has reached the bottom-right PE accumulator.

---
 rtl/systolic_feeder.sv | 219 +++++++++++++++++++++
 tb/tb_systolic_feeder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - operand buffer and skewed/broadcast stream feeder for an NxN systolic array
//
// Loads matrix A row-by-row and matrix B column-by-column over a valid/ready
// port, then replays them as per-row a-streams and per-column b-streams.
// With SKEW=1, lane k is delayed by k cycles for registered-hop arrays. With
// SKEW=0, all lanes are aligned for pass-through arrays. o_done pulses once the
// last product has reached the bottom-right PE.
//
// Parameters:
//   N     array dimension (2..16)
//   SKEW  1 = lane k delayed by k cycles, 0 = lanes aligned
//
// Ports:
//   i_clk     clock
//   i_arst    asynchronous active-high reset
//   i_valid   load beat valid
//   o_ready   load beat accepted when i_valid && o_ready at the clock edge
//   i_a_row   row k of A, element m in bits [8m+7:8m]
//   i_b_col   column k of B, element m in bits [8m+7:8m]
//   o_a       a-operand for array row i, in lane i
//   o_b       b-operand for array column j, in lane j
//   o_feed    high during FEED
//   o_busy    high during FEED or DRAIN
//   o_done    single-cycle completion pulse
//
// Optional feature macro: SYSTOLIC_FEEDER_DBUF_EN
//   Adds a second buffer bank so the next job can load while the current one
//   feeds.

module systolic_feeder #(
    parameter int N    = 4,
    parameter int SKEW = 1
) (
    input  logic           i_clk,
    input  logic           i_arst,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [8*N-1:0] i_a_row,
    input  logic [8*N-1:0] i_b_col,
    output logic [8*N-1:0] o_a,
    output logic [8*N-1:0] o_b,
    output logic           o_feed,
    output logic           o_busy,
    output logic           o_done
);
    localparam int L    = (SKEW != 0) ? 2*N-1 : N;
    localparam int D    = (SKEW != 0) ? 2*(N-1) : 0;
    localparam int MAXC = (L > D) ? ((L > N) ? L : N) : ((D > N) ? D : N);
    localparam int CW   = $clog2(MAXC+1);

    localparam logic [CW-1:0] BEAT_LAST  = CW'(N-1);
    localparam logic [CW-1:0] FEED_LAST  = CW'(L-1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(D-1);

`ifdef SYSTOLIC_FEEDER_DBUF_EN
    localparam int NB = 2;
    localparam logic [CW-1:0] BEAT_FULL = CW'(N);
`else
    localparam int NB = 1;
`endif

    typedef enum logic [1:0] {S_LOAD, S_FEED, S_DRAIN, S_DONE} state_t;

    // a_mem[bank][k] holds row k of A; b_mem[bank][k] holds column k of B.
    logic [8*N-1:0] a_mem [NB][N];
    logic [8*N-1:0] b_mem [NB][N];

    state_t        state, state_n;
    logic [CW-1:0] beat_cnt, beat_n;
    logic [CW-1:0] t_cnt, t_n;
    logic [CW-1:0] d_cnt, d_n;
    logic          act_bank, bank_n;   // bank being fed (and filled while in LOAD)
    logic          wr_bank;
    logic          accept;
    logic          wr_hit;
    logic          ready_n;
    logic [8*N-1:0] a_n, b_n;
    logic [8*N-1:0] a_row, b_row;

    assign accept = i_valid && o_ready;

`ifdef SYSTOLIC_FEEDER_DBUF_EN
    // Outside LOAD, beats go to the shadow bank.
    assign wr_bank = (state == S_LOAD) ? act_bank : ~act_bank;
`else
    assign wr_bank = 1'b0;
`endif

    always_comb begin
        state_n = state;
        beat_n  = beat_cnt;
        t_n     = t_cnt;
        d_n     = d_cnt;
        bank_n  = act_bank;
        if (accept) begin
            beat_n = beat_cnt + 1'b1;
        end
        case (state)
            S_LOAD: begin
                if (accept && beat_cnt == BEAT_LAST) begin
                    state_n = S_FEED;
                    beat_n  = '0;
                    t_n     = '0;
                end
            end
            S_FEED: begin
                if (t_cnt == FEED_LAST) begin
                    if (D > 0) begin
                        state_n = S_DRAIN;
                        d_n     = '0;
                    end else begin
                        state_n = S_DONE;
                    end
                end else begin
                    t_n = t_cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (d_cnt == DRAIN_LAST) begin
                    state_n = S_DONE;
                end else begin
                    d_n = d_cnt + 1'b1;
                end
            end
            S_DONE: begin
`ifdef SYSTOLIC_FEEDER_DBUF_EN
                bank_n = ~act_bank;
                if (beat_n == BEAT_FULL) begin
                    state_n = S_FEED;
                    beat_n  = '0;
                    t_n     = '0;
                end else begin
                    state_n = S_LOAD;
                end
`else
                state_n = S_LOAD;
                beat_n  = '0;
`endif
            end
            default: state_n = S_LOAD;
        endcase
    end

`ifdef SYSTOLIC_FEEDER_DBUF_EN
    assign ready_n = (beat_n != BEAT_FULL);
`else
    assign ready_n = (state_n == S_LOAD);
`endif

    // A beat written on this edge into the bank fed next cycle must be seen
    // by the first feed cycle, so its data is forwarded around the buffer.
    assign wr_hit = accept && (wr_bank == bank_n);

    always_comb begin
        a_n   = '0;
        b_n   = '0;
        a_row = '0;
        b_row = '0;
        for (int i = 0; i < N; i++) begin
            a_row = a_mem[bank_n][i];
            b_row = b_mem[bank_n][i];
            if (wr_hit && beat_cnt == CW'(i)) begin
                a_row = i_a_row;
                b_row = i_b_col;
            end
            if (state_n == S_FEED) begin
                for (int m = 0; m < N; m++) begin
                    if (int'(t_n) - i*SKEW == m) begin
                        a_n[8*i +: 8] = a_row[8*m +: 8];
                        b_n[8*i +: 8] = b_row[8*m +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state    <= S_LOAD;
            beat_cnt <= '0;
            t_cnt    <= '0;
            d_cnt    <= '0;
            act_bank <= 1'b0;
            o_ready  <= 1'b0;
            o_a      <= '0;
            o_b      <= '0;
            o_feed   <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            for (int bk = 0; bk < NB; bk++) begin
                for (int k = 0; k < N; k++) begin
                    a_mem[bk][k] <= '0;
                    b_mem[bk][k] <= '0;
                end
            end
        end else begin
            state    <= state_n;
            beat_cnt <= beat_n;
            t_cnt    <= t_n;
            d_cnt    <= d_n;
            act_bank <= bank_n;
            o_ready  <= ready_n;
            o_a      <= a_n;
            o_b      <= b_n;
            o_feed   <= (state_n == S_FEED);
            o_busy   <= (state_n == S_FEED) || (state_n == S_DRAIN);
            o_done   <= (state_n == S_DONE);
            if (accept) begin
                for (int k = 0; k < N; k++) begin
                    if (beat_cnt == CW'(k)) begin
                        a_mem[wr_bank][k] <= i_a_row;
                        b_mem[wr_bank][k] <= i_b_col;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - self-checking bench for systolic_feeder (SKEW=1 and SKEW=0 instances, N=4)

module tb_systolic_feeder;
    localparam int N = 4;
    localparam int W = 8*N;

    logic         clk   = 1'b0;
    logic         arst  = 1'b0;
    logic         valid = 1'b0;
    logic [W-1:0] a_in  = '0;
    logic [W-1:0] b_in  = '0;

    // index 0: SKEW=0 instance, index 1: SKEW=1 instance
    logic         ready [2];
    logic [W-1:0] oa    [2];
    logic [W-1:0] ob    [2];
    logic         feed  [2];
    logic         busy  [2];
    logic         done  [2];

    systolic_feeder #(.N(N), .SKEW(0)) dut0 (
        .i_clk(clk), .i_arst(arst), .i_valid(valid), .o_ready(ready[0]),
        .i_a_row(a_in), .i_b_col(b_in), .o_a(oa[0]), .o_b(ob[0]),
        .o_feed(feed[0]), .o_busy(busy[0]), .o_done(done[0])
    );

    systolic_feeder #(.N(N), .SKEW(1)) dut1 (
        .i_clk(clk), .i_arst(arst), .i_valid(valid), .o_ready(ready[1]),
        .i_a_row(a_in), .i_b_col(b_in), .o_a(oa[1]), .o_b(ob[1]),
        .o_feed(feed[1]), .o_busy(busy[1]), .o_done(done[1])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: matrices as the spec describes them, and a queue of
    // expected output cycles built from the feed formula when a job starts.
    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         feed;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t       exq [2][$];
    exp_t       cur [2];
    logic       cur_ready [2];
    int         beats [2];
    logic [7:0] mA [2][N][N];   // mA[s][row][col]
    logic [7:0] mB [2][N][N];   // mB[s][row][col]

    // per-test history of sampled outputs
    logic [W-1:0] h_a [2][64];
    logic [W-1:0] h_b [2][64];
    logic         h_feed [2][64];
    logic         h_busy [2][64];
    logic         h_done [2][64];
    logic         h_ready [2][64];
    int           rec;

    typedef struct {
        int           dut;
        int           idx;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } vec_t;
    vec_t tab [7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pk(input int s);
        return 128'({oa[s], ob[s], feed[s], busy[s], done[s], ready[s]});
    endfunction

    function automatic logic [127:0] pk_exp(input int s);
        return 128'({cur[s].a, cur[s].b, cur[s].feed, cur[s].busy, cur[s].done, cur_ready[s]});
    endfunction

    task automatic push_job(input int s);
        int   skew;
        int   len_l;
        int   len_d;
        int   k;
        exp_t e;
        skew  = (s == 1) ? 1 : 0;
        len_l = (skew != 0) ? 2*N-1 : N;
        len_d = (skew != 0) ? 2*(N-1) : 0;
        for (int t = 0; t < len_l; t++) begin
            e      = '0;
            e.feed = 1'b1;
            e.busy = 1'b1;
            for (int i = 0; i < N; i++) begin
                k = t - i*skew;
                if (k >= 0 && k < N) begin
                    e.a[8*i +: 8] = mA[s][i][k];
                    e.b[8*i +: 8] = mB[s][k][i];
                end
            end
            exq[s].push_back(e);
        end
        for (int d = 0; d < len_d; d++) begin
            e      = '0;
            e.busy = 1'b1;
            exq[s].push_back(e);
        end
        e      = '0;
        e.done = 1'b1;
        exq[s].push_back(e);
    endtask

    task automatic model_edge(input int s, input logic v, input logic [W-1:0] ar, input logic [W-1:0] bc);
        logic was_idle;
        logic was_done;
        was_idle = !(cur[s].feed || cur[s].busy || cur[s].done);
        was_done = cur[s].done;
        if (v && cur_ready[s]) begin
            for (int m = 0; m < N; m++) begin
                mA[s][beats[s]][m] = ar[8*m +: 8];
                mB[s][m][beats[s]] = bc[8*m +: 8];
            end
            beats[s]++;
        end
        if (beats[s] == N && (was_idle || was_done)) begin
            push_job(s);
            beats[s] = 0;
        end
        if (exq[s].size() > 0) cur[s] = exq[s].pop_front();
        else                   cur[s] = '0;
`ifdef SYSTOLIC_FEEDER_DBUF_EN
        cur_ready[s] = (beats[s] < N);
`else
        cur_ready[s] = !(cur[s].feed || cur[s].busy || cur[s].done);
`endif
    endtask

    // Called at a negedge: drive, let one posedge pass, sample at the next negedge.
    task automatic cycle(input logic v, input logic [W-1:0] ar, input logic [W-1:0] bc);
        valid = v;
        a_in  = ar;
        b_in  = bc;
        @(posedge clk);
        model_edge(0, v, ar, bc);
        model_edge(1, v, ar, bc);
        @(negedge clk);
        chk("dut0 outputs", pk(0), pk_exp(0));
        chk("dut1 outputs", pk(1), pk_exp(1));
        if (rec < 64) begin
            for (int s = 0; s < 2; s++) begin
                h_a[s][rec]     = oa[s];
                h_b[s][rec]     = ob[s];
                h_feed[s][rec]  = feed[s];
                h_busy[s][rec]  = busy[s];
                h_done[s][rec]  = done[s];
                h_ready[s][rec] = ready[s];
            end
        end
        rec++;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            cur[s]       = '0;
            cur_ready[s] = 1'b0;
            beats[s]     = 0;
            exq[s].delete();
            chk("reset outputs immediate", pk(s), '0);
        end
        @(negedge clk);
        for (int s = 0; s < 2; s++) chk("reset outputs held", pk(s), '0);
        arst = 1'b0;
        cycle(1'b0, '0, '0);
    endtask

    initial begin
        logic [W-1:0] ar;
        logic [W-1:0] bc;
        logic [W-1:0] t3a [N];
        logic [W-1:0] ex;
        int           cnt;
        int           kk;
        int           pat [7];

        tab[0] = '{1, 3, 32'h00000001, 32'h00000001};
        tab[1] = '{1, 4, 32'h00000502, 32'h00000000};
        tab[2] = '{1, 6, 32'h0D0A0704, 32'h00000000};
        tab[3] = '{1, 9, 32'h10000000, 32'h01000000};
        tab[4] = '{0, 3, 32'h0D090501, 32'h00000001};
        tab[5] = '{0, 5, 32'h0F0B0703, 32'h00010000};
        tab[6] = '{0, 6, 32'h100C0804, 32'h01000000};
        pat    = '{1, 0, 0, 1, 1, 0, 1};

        rec = 0;
        do_reset();

        // Test 1/2: A = 1..16 row-major, B = identity, 4 back-to-back beats
        rec = 0;
        for (int k = 0; k < N; k++) begin
            ar = '0;
            bc = '0;
            for (int m = 0; m < N; m++) begin
                ar[8*m +: 8] = 8'(4*k + m + 1);
                if (m == k) bc[8*m +: 8] = 8'd1;
            end
            cycle(1'b1, ar, bc);
        end
        repeat (16) cycle(1'b0, '0, '0);
        for (int v = 0; v < 7; v++) begin
            chk($sformatf("table a dut%0d idx%0d", tab[v].dut, tab[v].idx), 128'(h_a[tab[v].dut][tab[v].idx]), 128'(tab[v].a));
            chk($sformatf("table b dut%0d idx%0d", tab[v].dut, tab[v].idx), 128'(h_b[tab[v].dut][tab[v].idx]), 128'(tab[v].b));
        end
        for (int s = 0; s < 2; s++) begin
            cnt = 0;
            for (int i = 0; i < 20; i++) if (h_feed[s][i]) cnt++;
            chk($sformatf("feed cycle count dut%0d", s), 128'(cnt), (s == 1) ? 128'd7 : 128'd4);
        end
        chk("dut1 feed rises idx3", 128'({h_feed[1][2], h_feed[1][3]}), 128'b01);
        chk("dut1 done 13 after feed", 128'({h_done[1][15], h_done[1][16], h_done[1][17]}), 128'b010);
        chk("dut0 done 4 after feed", 128'({h_done[0][6], h_done[0][7], h_done[0][8]}), 128'b010);
        chk("dut0 ready after done", 128'({h_ready[0][7], h_ready[0][8]}), 128'b01);

        // Test 3: gapped valid, then valid held high during FEED
        rec = 0;
        kk  = 0;
        for (int p = 0; p < 7; p++) begin
            ar = $urandom;
            bc = $urandom;
            if (pat[p] != 0) begin
                t3a[kk] = ar;
                kk++;
            end
            cycle(pat[p] != 0, ar, bc);
        end
        repeat (3) cycle(1'b1, $urandom, $urandom);
        repeat (16) cycle(1'b0, '0, '0);
        chk("gap load feed start", 128'({h_feed[1][5], h_feed[1][6]}), 128'b01);
        ex = '0;
        for (int i = 0; i < N; i++) ex[8*i +: 8] = t3a[i][7:0];
        chk("gap load beat order dut0 t0", 128'(h_a[0][6]), 128'(ex));
`ifndef SYSTOLIC_FEEDER_DBUF_EN
        chk("ready low during feed", 128'({h_ready[1][7], h_ready[1][8], h_ready[1][9]}), 128'b000);
`endif

        // Test 4: reset at feed t=3, then a fresh load
        rec = 0;
        for (int k = 0; k < N; k++) cycle(1'b1, $urandom, $urandom);
        repeat (3) cycle(1'b0, '0, '0);
        chk("dut1 at t3 before reset", 128'(feed[1]), 128'd1);
        do_reset();
        repeat (4) cycle(1'b0, '0, '0);
        for (int k = 0; k < N; k++) cycle(1'b1, $urandom, $urandom);
        repeat (16) cycle(1'b0, '0, '0);

        // Test 5: a second job offered while the first feeds
        rec = 0;
        for (int k = 0; k < 2*N; k++) cycle(1'b1, $urandom, $urandom);
        repeat (30) cycle(1'b0, '0, '0);
`ifdef SYSTOLIC_FEEDER_DBUF_EN
        chk("dbuf job2 feed after done", 128'({h_done[1][16], h_feed[1][16], h_feed[1][17]}), 128'b101);
`else
        chk("no overlap ready during feed", 128'({h_ready[1][4], h_ready[1][5]}), 128'b00);
        chk("no second job", 128'(h_feed[1][17]), 128'd0);
`endif

        // Test 6: all operands 0xFF
        rec = 0;
        for (int k = 0; k < N; k++) cycle(1'b1, '1, '1);
        repeat (16) cycle(1'b0, '0, '0);
        chk("ff t0 lane0 only", 128'(h_a[1][3]), 128'h000000FF);
        chk("ff t3 all lanes", 128'(h_a[1][6]), 128'hFFFFFFFF);
        chk("ff b t6 lane3 only", 128'(h_b[1][9]), 128'hFF000000);
        chk("ff busy low on done", 128'({h_busy[1][16], h_done[1][16]}), 128'b01);

        // Random jobs with random valid gaps and one reset in the middle
        for (int c = 0; c < 300; c++) begin
            if (c == 150) do_reset();
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom);
        end
        repeat (40) cycle(1'b0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
